// File: rtl/vga_sync_if.sv
// ----------------------------------------------------------------------------
// vga_sync_if
// Purpose : Bundles the registered VGA timing outputs that the sync generator
//           hands to the pattern / lock-screen renderer.
// Signals : hsync, vsync   - sync pulses, asserted level set by the generator
//           video_on       - 1 while (pixel_x, pixel_y) is inside the visible area
//           pixel_x/_y     - raw horizontal / vertical position (CNT_W bits)
//           line_start     - one-cycle pulse when pixel_x == 0
//           frame_start    - one-cycle pulse when pixel_x == 0 and pixel_y == 0
// Modports: master (generator drives), slave (renderer consumes)
// ----------------------------------------------------------------------------
interface vga_sync_if #(
    parameter int CNT_W = 10
);
    logic             hsync;
    logic             vsync;
    logic             video_on;
    logic [CNT_W-1:0] pixel_x;
    logic [CNT_W-1:0] pixel_y;
    logic             line_start;
    logic             frame_start;

    modport master (
        output hsync, vsync, video_on, pixel_x, pixel_y, line_start, frame_start
    );

    modport slave (
        input  hsync, vsync, video_on, pixel_x, pixel_y, line_start, frame_start
    );
endinterface

// File: rtl/vga_sync_generator.sv
// ----------------------------------------------------------------------------
// vga_sync_generator
// Purpose : VGA timing core running on the divided pixel clock. Produces
//           hsync/vsync, an active-video flag and the current pixel
//           coordinates. Default timing is 640x480@60 (800 x 525 clocks).
//           Every output is registered so the sync pins are glitch-free.
// Ports   : clock_in - pixel clock from the clock divider
//           reset    - asynchronous, active-high reset
//           o_vga    - vga_sync_if master modport carrying all timing outputs
// ----------------------------------------------------------------------------
module vga_sync_generator #(
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter bit SYNC_POL  = 1'b0,
    parameter int CNT_W     = 10
) (
    input  logic          clock_in,
    input  logic          reset,
    vga_sync_if.master    o_vga
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    // Last count of each region; a region is left when its counter sits here.
    localparam logic [CNT_W-1:0] H_VIS_END   = CNT_W'(H_VISIBLE - 1);
    localparam logic [CNT_W-1:0] H_FRONT_END = CNT_W'(H_VISIBLE + H_FRONT - 1);
    localparam logic [CNT_W-1:0] H_SYNC_END  = CNT_W'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam logic [CNT_W-1:0] H_LAST      = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_VIS_END   = CNT_W'(V_VISIBLE - 1);
    localparam logic [CNT_W-1:0] V_FRONT_END = CNT_W'(V_VISIBLE + V_FRONT - 1);
    localparam logic [CNT_W-1:0] V_SYNC_END  = CNT_W'(V_VISIBLE + V_FRONT + V_SYNC - 1);
    localparam logic [CNT_W-1:0] V_LAST      = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO    = '0;
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    typedef enum logic [1:0] {
        REGION_VISIBLE,
        REGION_FRONT,
        REGION_SYNC,
        REGION_BACK
    } region_t;

    logic [CNT_W-1:0] r_hCnt;
    logic [CNT_W-1:0] r_vCnt;
    region_t          r_hState;
    region_t          r_vState;

    logic             r_hsync;
    logic             r_vsync;
    logic             r_videoOn;
    logic [CNT_W-1:0] r_pixelX;
    logic [CNT_W-1:0] r_pixelY;
    logic             r_lineStart;
    logic             r_frameStart;

    logic             w_hWrap;
    logic             w_vWrap;

    assign w_hWrap = (r_hCnt == H_LAST);
    assign w_vWrap = (r_vCnt == V_LAST);

    // Region sequencing shared by both axes: the state always describes the
    // region of the counter value it is registered alongside, so it steps
    // forward when the counter sits on the last count of the current region.
    function automatic region_t nextRegion(
        input region_t          cur,
        input logic [CNT_W-1:0] cnt,
        input logic [CNT_W-1:0] visEnd,
        input logic [CNT_W-1:0] frontEnd,
        input logic [CNT_W-1:0] syncEnd,
        input logic [CNT_W-1:0] lastCnt
    );
        region_t nxt;
        nxt = cur;
        case (cur)
            REGION_VISIBLE: if (cnt == visEnd)   nxt = REGION_FRONT;
            REGION_FRONT:   if (cnt == frontEnd) nxt = REGION_SYNC;
            REGION_SYNC:    if (cnt == syncEnd)  nxt = REGION_BACK;
            REGION_BACK:    if (cnt == lastCnt)  nxt = REGION_VISIBLE;
            default:        nxt = REGION_VISIBLE;
        endcase
        return nxt;
    endfunction

    // Position counters and the two region FSMs. The horizontal side advances
    // every pixel clock; the vertical side only moves when a line wraps.
    // Wrapping is by compare so non power-of-two totals work in any width.
    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            r_hCnt   <= CNT_ZERO;
            r_vCnt   <= CNT_ZERO;
            r_hState <= REGION_VISIBLE;
            r_vState <= REGION_VISIBLE;
        end else begin
            r_hCnt   <= w_hWrap ? CNT_ZERO : r_hCnt + CNT_ONE;
            r_hState <= nextRegion(r_hState, r_hCnt, H_VIS_END, H_FRONT_END,
                                   H_SYNC_END, H_LAST);
            if (w_hWrap) begin
                r_vCnt   <= w_vWrap ? CNT_ZERO : r_vCnt + CNT_ONE;
                r_vState <= nextRegion(r_vState, r_vCnt, V_VIS_END, V_FRONT_END,
                                       V_SYNC_END, V_LAST);
            end
        end
    end

    // Output stage, one register deep. Everything here is decoded from the
    // same counter / region snapshot, so all outputs lag the counters by
    // exactly one clock and always agree with each other. Coordinates are
    // passed through raw during blanking; consumers gate on video_on.
    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            r_hsync      <= ~SYNC_POL;
            r_vsync      <= ~SYNC_POL;
            r_videoOn    <= 1'b0;
            r_pixelX     <= CNT_ZERO;
            r_pixelY     <= CNT_ZERO;
            r_lineStart  <= 1'b0;
            r_frameStart <= 1'b0;
        end else begin
            r_hsync      <= (r_hState == REGION_SYNC) ? SYNC_POL : ~SYNC_POL;
            r_vsync      <= (r_vState == REGION_SYNC) ? SYNC_POL : ~SYNC_POL;
            r_videoOn    <= (r_hState == REGION_VISIBLE) && (r_vState == REGION_VISIBLE);
            r_pixelX     <= r_hCnt;
            r_pixelY     <= r_vCnt;
            r_lineStart  <= (r_hCnt == CNT_ZERO);
            r_frameStart <= (r_hCnt == CNT_ZERO) && (r_vCnt == CNT_ZERO);
        end
    end

    assign o_vga.hsync       = r_hsync;
    assign o_vga.vsync       = r_vsync;
    assign o_vga.video_on    = r_videoOn;
    assign o_vga.pixel_x     = r_pixelX;
    assign o_vga.pixel_y     = r_pixelY;
    assign o_vga.line_start  = r_lineStart;
    assign o_vga.frame_start = r_frameStart;

endmodule
